// File: rtl/csr_sched.sv
`default_nettype none
// ============================================================================
// Module      : csr_sched
// Description : Sequencer/arbiter in front of the single-ported csr unit.
//               Accepts system-op requests from execute and page-fault
//               reports from the MMU. Issues one operation per sequence onto
//               the csr cause/tval/wdata interface. Resolves the result as a
//               write-back response, a pipeline redirect, or a TLB flush
//               followed by a redirect.
// Ports       : clk, rst             - clock, asynchronous active-high reset
//               exec_*               - execute-stage request / completion
//               fault_*              - MMU page-fault pulse and drop report
//               csr_* (out)          - operation driven to the csr unit
//               csr_* (in)           - combinational results from csr
//               tlb_flush_req/ack    - TLB flush handshake
//               redirect_valid/pc    - global pipeline redirect
//               busy                 - sequence in flight or fault pending
// Revision    : 1.0 - initial release
// ============================================================================
module csr_sched #(
    parameter logic [4:0] IDLE_CAUSE = 5'd0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        exec_valid,
    output logic        exec_ready,
    input  logic [4:0]  exec_cause,
    input  logic [63:0] exec_pc,
    input  logic [63:0] exec_addr,
    input  logic [63:0] exec_wdata,
    output logic        exec_done,
    output logic [63:0] exec_rdata,

    input  logic        fault_valid,
    input  logic [4:0]  fault_cause,
    input  logic [63:0] fault_pc,
    input  logic [63:0] fault_va,
    output logic        fault_drop,

    output logic [4:0]  csr_cause,
    output logic [63:0] csr_pc,
    output logic [63:0] csr_tval,
    output logic [63:0] csr_wdata,
    input  logic [63:0] csr_rdata,
    input  logic        csr_r_valid,
    input  logic        csr_trap_en,
    input  logic [63:0] csr_trap_pc,
    input  logic        csr_invalid,

    output logic        tlb_flush_req,
    input  logic        tlb_flush_ack,

    output logic        redirect_valid,
    output logic [63:0] redirect_pc,

    output logic        busy
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    state_t      r_state;

    // Single-entry fault buffer
    logic        r_fb_full;
    logic [4:0]  r_fb_cause;
    logic [63:0] r_fb_pc;
    logic [63:0] r_fb_va;

    // Per-sequence context
    logic        r_src_exec;
    logic [63:0] r_rdata;
    logic [63:0] r_trap_pc;

    // Registered outputs
    logic [4:0]  r_csr_cause;
    logic [63:0] r_csr_pc;
    logic [63:0] r_csr_tval;
    logic [63:0] r_csr_wdata;
    logic        r_exec_done;
    logic [63:0] r_exec_rdata;
    logic        r_redirect_valid;
    logic [63:0] r_redirect_pc;
    logic        r_tlb_flush_req;

    logic        w_idle;
    logic        w_fb_launch;
    logic        w_exec_ready;
    logic        w_exec_launch;
    logic        w_fault_drop;
    logic [63:0] w_rdata_v;

    assign w_idle        = (r_state == ST_IDLE);
    // A buffered fault always goes first out of IDLE.
    assign w_fb_launch   = w_idle & r_fb_full;
    // A same-cycle fault pulse blocks accept so the fault wins arbitration.
    // Reset masks the accept so no output is high while rst is asserted.
    assign w_exec_ready  = ~rst & w_idle & ~r_fb_full & ~fault_valid;
    assign w_exec_launch = w_exec_ready & exec_valid;
    // A pulse that meets a full buffer is lost unless the slot frees this cycle.
    assign w_fault_drop  = ~rst & fault_valid & r_fb_full & ~w_fb_launch;
    assign w_rdata_v     = csr_r_valid ? csr_rdata : 64'd0;

    // ------------------------------------------------------------------
    // Fault buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fb_full  <= 1'b0;
            r_fb_cause <= 5'd0;
            r_fb_pc    <= 64'd0;
            r_fb_va    <= 64'd0;
        end else if (fault_valid && (!r_fb_full || w_fb_launch)) begin
            // Launch reads the old contents on this same edge, so a new
            // fault may refill the slot as it is being vacated.
            r_fb_full  <= 1'b1;
            r_fb_cause <= fault_cause;
            r_fb_pc    <= fault_pc;
            r_fb_va    <= fault_va;
        end else if (w_fb_launch) begin
            r_fb_full  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_src_exec       <= 1'b0;
            r_rdata          <= 64'd0;
            r_trap_pc        <= 64'd0;
            r_csr_cause      <= IDLE_CAUSE;
            r_csr_pc         <= 64'd0;
            r_csr_tval       <= 64'd0;
            r_csr_wdata      <= 64'd0;
            r_exec_done      <= 1'b0;
            r_exec_rdata     <= 64'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 64'd0;
            r_tlb_flush_req  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fb_launch) begin
                        r_src_exec  <= 1'b0;
                        r_csr_cause <= r_fb_cause;
                        r_csr_pc    <= r_fb_pc;
                        r_csr_tval  <= r_fb_va;
                        r_csr_wdata <= 64'd0;
                        r_state     <= ST_ISSUE;
                    end else if (w_exec_launch) begin
                        r_src_exec  <= 1'b1;
                        r_csr_cause <= exec_cause;
                        r_csr_pc    <= exec_pc;
                        r_csr_tval  <= exec_addr;
                        r_csr_wdata <= exec_wdata;
                        r_state     <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // pc/tval/wdata keep their values; only the cause
                    // returns to idle so csr sees exactly one operation.
                    r_csr_cause <= IDLE_CAUSE;
                    r_rdata     <= w_rdata_v;
                    r_trap_pc   <= csr_trap_pc;
                    if (csr_invalid) begin
                        r_tlb_flush_req <= 1'b1;
                        r_state         <= ST_FLUSH;
                    end else if (csr_trap_en) begin
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= csr_trap_pc;
                        r_exec_done      <= r_src_exec;
                        r_exec_rdata     <= r_src_exec ? w_rdata_v : 64'd0;
                        r_state          <= ST_REDIRECT;
                    end else begin
                        r_exec_done      <= r_src_exec;
                        r_exec_rdata     <= r_src_exec ? w_rdata_v : 64'd0;
                        r_state          <= ST_RESP;
                    end
                end

                ST_FLUSH: begin
                    if (tlb_flush_ack) begin
                        r_tlb_flush_req  <= 1'b0;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= r_trap_pc;
                        r_exec_done      <= r_src_exec;
                        r_exec_rdata     <= r_src_exec ? r_rdata : 64'd0;
                        r_state          <= ST_REDIRECT;
                    end
                end

                ST_REDIRECT, ST_RESP: begin
                    r_redirect_valid <= 1'b0;
                    r_redirect_pc    <= 64'd0;
                    r_exec_done      <= 1'b0;
                    r_exec_rdata     <= 64'd0;
                    r_state          <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign exec_ready     = w_exec_ready;
    assign exec_done      = r_exec_done;
    assign exec_rdata     = r_exec_rdata;
    assign fault_drop     = w_fault_drop;
    assign csr_cause      = r_csr_cause;
    assign csr_pc         = r_csr_pc;
    assign csr_tval       = r_csr_tval;
    assign csr_wdata      = r_csr_wdata;
    assign tlb_flush_req  = r_tlb_flush_req;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign busy           = ~w_idle | r_fb_full;

endmodule
`default_nettype wire

// File: tb/tb_csr_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_sched
// Description : Self-checking bench for csr_sched. Emulates the csr unit,
//               drives directed and random traffic and compares every cycle
//               against a sequence-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_sched;

    localparam logic [4:0]  c_idle_cause   = 5'd0;
    localparam logic [4:0]  c_sysop_csr_w  = 5'd1;
    localparam logic [4:0]  c_sysop_csr_s  = 5'd2;
    localparam logic [4:0]  c_sysop_csr_c  = 5'd3;
    localparam logic [4:0]  c_sysop_ecall  = 5'd4;
    localparam logic [4:0]  c_sysop_ret    = 5'd5;
    localparam logic [4:0]  c_mc_inst_pf   = 5'd12;
    localparam logic [4:0]  c_mc_load_pf   = 5'd13;
    localparam logic [11:0] c_a_mscratch   = 12'h340;
    localparam logic [11:0] c_a_mtvec      = 12'h305;
    localparam logic [11:0] c_a_mepc       = 12'h341;
    localparam logic [11:0] c_a_mcause     = 12'h342;
    localparam logic [11:0] c_a_mtval      = 12'h343;
    localparam logic [11:0] c_a_satp       = 12'h180;
    localparam logic [11:0] c_a_bad        = 12'h7c0;

    typedef struct packed {
        logic [63:0] mscratch, mtvec, mepc, mcause, mtval, satp;
    } regs_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        r_valid;
        logic        trap_en;
        logic [63:0] trap_pc;
        logic        invalid;
        regs_t       nxt;
    } res_t;

    // Behaviour of the csr unit for one issued operation.
    function automatic res_t csr_eval(regs_t r, logic [4:0] cause, logic [63:0] pc,
                                      logic [63:0] tval, logic [63:0] wdata);
        res_t o;
        logic [63:0] old;
        logic [63:0] nv;
        logic hit;
        o = '0;
        o.nxt = r;
        old = 64'd0;
        nv = 64'd0;
        hit = 1'b1;
        case (cause)
            c_sysop_csr_w, c_sysop_csr_s, c_sysop_csr_c: begin
                case (tval[11:0])
                    c_a_mscratch: old = r.mscratch;
                    c_a_mtvec:    old = r.mtvec;
                    c_a_mepc:     old = r.mepc;
                    c_a_mcause:   old = r.mcause;
                    c_a_mtval:    old = r.mtval;
                    c_a_satp:     old = r.satp;
                    default:      hit = 1'b0;
                endcase
                if (hit) begin
                    if (cause == c_sysop_csr_w)      nv = wdata;
                    else if (cause == c_sysop_csr_s) nv = old | wdata;
                    else                             nv = old & ~wdata;
                    o.rdata = old;
                    o.r_valid = 1'b1;
                    case (tval[11:0])
                        c_a_mscratch: o.nxt.mscratch = nv;
                        c_a_mtvec:    o.nxt.mtvec = nv;
                        c_a_mepc:     o.nxt.mepc = nv;
                        c_a_mcause:   o.nxt.mcause = nv;
                        c_a_mtval:    o.nxt.mtval = nv;
                        default:      o.nxt.satp = nv;
                    endcase
                    if (tval[11:0] == c_a_satp) begin
                        o.invalid = 1'b1;
                        o.trap_pc = pc + 64'd4;
                    end
                end
            end
            c_sysop_ecall: begin
                o.trap_en = 1'b1;
                o.trap_pc = r.mtvec;
                o.nxt.mepc = pc;
                o.nxt.mcause = 64'd11;
            end
            c_sysop_ret: begin
                o.trap_en = 1'b1;
                o.trap_pc = r.mepc;
            end
            c_mc_inst_pf, c_mc_load_pf: begin
                o.trap_en = 1'b1;
                o.trap_pc = r.mtvec;
                o.nxt.mepc = pc;
                o.nxt.mtval = tval;
                o.nxt.mcause = {59'd0, cause};
            end
            default: ;
        endcase
        return o;
    endfunction

    // ---------------- DUT signals ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exec_valid = 1'b0;
    logic        exec_ready;
    logic [4:0]  exec_cause = 5'd0;
    logic [63:0] exec_pc = 64'd0;
    logic [63:0] exec_addr = 64'd0;
    logic [63:0] exec_wdata = 64'd0;
    logic        exec_done;
    logic [63:0] exec_rdata;
    logic        fault_valid = 1'b0;
    logic [4:0]  fault_cause = 5'd0;
    logic [63:0] fault_pc = 64'd0;
    logic [63:0] fault_va = 64'd0;
    logic        fault_drop;
    logic [4:0]  csr_cause;
    logic [63:0] csr_pc;
    logic [63:0] csr_tval;
    logic [63:0] csr_wdata;
    logic [63:0] csr_rdata;
    logic        csr_r_valid;
    logic        csr_trap_en;
    logic [63:0] csr_trap_pc;
    logic        csr_invalid;
    logic        tlb_flush_req;
    logic        tlb_flush_ack = 1'b0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        busy;

    always #5 clk = ~clk;

    csr_sched #(.IDLE_CAUSE(5'd0)) dut (
        .clk(clk), .rst(rst),
        .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_cause(exec_cause),
        .exec_pc(exec_pc), .exec_addr(exec_addr), .exec_wdata(exec_wdata),
        .exec_done(exec_done), .exec_rdata(exec_rdata),
        .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_pc(fault_pc),
        .fault_va(fault_va), .fault_drop(fault_drop),
        .csr_cause(csr_cause), .csr_pc(csr_pc), .csr_tval(csr_tval), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_r_valid(csr_r_valid), .csr_trap_en(csr_trap_en),
        .csr_trap_pc(csr_trap_pc), .csr_invalid(csr_invalid),
        .tlb_flush_req(tlb_flush_req), .tlb_flush_ack(tlb_flush_ack),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .busy(busy)
    );

    // ---------------- csr unit emulation ----------------
    regs_t s_regs = '0;
    res_t  s_res;
    always_comb s_res = csr_eval(s_regs, csr_cause, csr_pc, csr_tval, csr_wdata);
    assign csr_rdata   = s_res.rdata;
    assign csr_r_valid = s_res.r_valid;
    assign csr_trap_en = s_res.trap_en;
    assign csr_trap_pc = s_res.trap_pc;
    assign csr_invalid = s_res.invalid;
    always @(posedge clk) if (csr_cause != c_idle_cause) s_regs <= s_res.nxt;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    regs_t       m_regs = '0;
    bit          m_fb_full = 1'b0;
    logic [4:0]  m_fb_cause;
    logic [63:0] m_fb_pc, m_fb_va;
    logic [63:0] m_last_pc = 64'd0, m_last_tval = 64'd0, m_last_wdata = 64'd0;
    bit          s_active = 1'b0;
    int          s_launch, s_free, s_d;
    bit          s_src_exec, s_flush, s_trap;
    logic [4:0]  s_cause;
    logic [63:0] s_pc, s_tval, s_wdata, s_trap_pc, s_rdata;
    regs_t       s_nxt;
    int          force_d = 0;

    bit          e_ready, e_busy, e_drop, e_flush, e_redir, e_done, m_acc;
    logic [4:0]  e_cause;
    logic [63:0] e_rpc, e_rdata;

    task automatic launch(input bit src, input logic [4:0] cause, input logic [63:0] pc,
                          input logic [63:0] tval, input logic [63:0] wdata);
        res_t r;
        r = csr_eval(m_regs, cause, pc, tval, wdata);
        s_active = 1'b1; s_launch = cyc; s_src_exec = src;
        s_cause = cause; s_pc = pc; s_tval = tval; s_wdata = wdata;
        s_flush = r.invalid; s_trap = r.trap_en; s_trap_pc = r.trap_pc;
        s_rdata = r.r_valid ? r.rdata : 64'd0;
        s_nxt = r.nxt;
        s_d = s_flush ? ((force_d > 0) ? force_d : int'($urandom_range(1, 6))) : 0;
        s_free = cyc + 3 + s_d;
    endtask

    task automatic model_step();
        int k;
        bit fl;
        m_acc = 0; e_ready = 0; e_busy = 0; e_drop = 0; e_flush = 0;
        e_redir = 0; e_done = 0; e_cause = c_idle_cause; e_rpc = 0; e_rdata = 0;
        fl = 0;
        if (rst) begin
            s_active = 0; m_fb_full = 0;
            m_last_pc = 0; m_last_tval = 0; m_last_wdata = 0;
            return;
        end
        if (s_active && cyc >= s_free) s_active = 0;
        if (s_active) begin
            k = cyc - s_launch;
            if (k == 1) begin
                e_cause = s_cause;
                m_last_pc = s_pc; m_last_tval = s_tval; m_last_wdata = s_wdata;
            end
            if (s_flush && k >= 2 && k <= 1 + s_d) e_flush = 1;
            if ((s_flush && k == 2 + s_d) || (!s_flush && s_trap && k == 2)) begin
                e_redir = 1; e_rpc = s_trap_pc; e_done = s_src_exec; e_rdata = s_rdata;
            end
            if (!s_flush && !s_trap && k == 2) begin
                e_done = s_src_exec; e_rdata = s_rdata;
            end
        end
        e_ready = !s_active && !m_fb_full && !fault_valid;
        e_busy  = s_active || m_fb_full;
        e_drop  = fault_valid && m_fb_full && s_active;
        if (!s_active && m_fb_full) begin
            launch(1'b0, m_fb_cause, m_fb_pc, m_fb_va, 64'd0);
            fl = 1;
        end else if (e_ready && exec_valid) begin
            launch(1'b1, exec_cause, exec_pc, exec_addr, exec_wdata);
            m_acc = 1;
        end
        if (fault_valid && (!m_fb_full || fl)) begin
            m_fb_full = 1; m_fb_cause = fault_cause; m_fb_pc = fault_pc; m_fb_va = fault_va;
        end else if (fl) begin
            m_fb_full = 0;
        end
        if (s_active && cyc == s_launch + 1) m_regs = s_nxt;
    endtask

    // ---------------- stimulus + compare ----------------
    bit          rst_next = 1'b1;
    bit          p_valid = 1'b0;
    logic [4:0]  p_cause = 5'd0;
    logic [63:0] p_pc = 64'd0, p_addr = 64'd0, p_wdata = 64'd0;
    bit          f_pend = 1'b0;
    logic [4:0]  f_cause = 5'd0;
    logic [63:0] f_pc = 64'd0, f_va = 64'd0;

    int          o_flush_cnt = 0, o_drop_cnt = 0, o_redir_cnt = 0;
    int          o_done_cyc = -1, o_redir_cyc = -1;
    logic [63:0] o_rdata = 64'd0, o_rpc = 64'd0;
    logic        o_ready = 1'b0;

    task automatic step();
        @(posedge clk); #1;
        rst = rst_next;
        fault_valid = f_pend; fault_cause = f_cause; fault_pc = f_pc; fault_va = f_va;
        f_pend = 0;
        exec_valid = p_valid; exec_cause = p_cause; exec_pc = p_pc;
        exec_addr = p_addr; exec_wdata = p_wdata;
        tlb_flush_ack = !rst && s_active && s_flush && (cyc == s_launch + 1 + s_d);
        model_step();
        @(negedge clk);
        chk("exec_ready",     64'(exec_ready),     64'(e_ready));
        chk("busy",           64'(busy),           64'(e_busy));
        chk("fault_drop",     64'(fault_drop),     64'(e_drop));
        chk("csr_cause",      64'(csr_cause),      64'(e_cause));
        chk("csr_pc",         csr_pc,              m_last_pc);
        chk("csr_tval",       csr_tval,            m_last_tval);
        chk("csr_wdata",      csr_wdata,           m_last_wdata);
        chk("tlb_flush_req",  64'(tlb_flush_req),  64'(e_flush));
        chk("redirect_valid", 64'(redirect_valid), 64'(e_redir));
        chk("exec_done",      64'(exec_done),      64'(e_done));
        if (e_done)  chk("exec_rdata",  exec_rdata,  e_rdata);
        if (e_redir) chk("redirect_pc", redirect_pc, e_rpc);
        if (tlb_flush_req) o_flush_cnt++;
        if (fault_drop) o_drop_cnt++;
        if (redirect_valid) begin o_redir_cnt++; o_rpc = redirect_pc; o_redir_cyc = cyc; end
        if (exec_done) begin o_rdata = exec_rdata; o_done_cyc = cyc; end
        o_ready = exec_ready;
        if (m_acc) p_valid = 0;
        cyc++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((s_active || m_fb_full || p_valid) && n < 300) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= 300) begin
            n_errors++;
            $display("FAIL wait_idle cyc=%0d actual=timeout required=idle", cyc);
        end
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        while (p_valid && n < 300) begin
            step();
            n++;
        end
        n_checks++;
        if (n >= 300) begin
            n_errors++;
            $display("FAIL wait_accept cyc=%0d actual=timeout required=accept", cyc);
        end
    endtask

    task automatic do_exec(input logic [4:0] cause, input logic [63:0] pc,
                           input logic [63:0] addr, input logic [63:0] wdata, output int t_acc);
        p_cause = cause; p_pc = pc; p_addr = addr; p_wdata = wdata; p_valid = 1;
        wait_accept();
        t_acc = cyc - 1;
        wait_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        int t, f0, r0, d0;
        int sel;
        logic [11:0] addrs [7];
        addrs = '{c_a_mscratch, c_a_mtvec, c_a_mepc, c_a_mcause, c_a_mtval, c_a_satp, c_a_bad};

        // Reset state
        rst_next = 1;
        step(); step();
        chk("rst_ready", 64'(exec_ready), 64'd0);
        chk("rst_cause", 64'(csr_cause), 64'(c_idle_cause));
        rst_next = 0;
        step();

        // CSR write / set
        do_exec(c_sysop_csr_w, 64'h8000_0000, {52'd0, c_a_mscratch}, 64'h1234, t);
        chk("w_done_lat", 64'(o_done_cyc - t), 64'd2);
        chk("w_rdata", o_rdata, 64'd0);
        do_exec(c_sysop_csr_s, 64'h8000_0004, {52'd0, c_a_mscratch}, 64'hF0, t);
        chk("s_rdata", o_rdata, 64'h1234);
        do_exec(c_sysop_csr_s, 64'h8000_0008, {52'd0, c_a_mscratch}, 64'h0, t);
        chk("s_readback", o_rdata, 64'h12F4);

        // ECALL
        do_exec(c_sysop_csr_w, 64'h8000_000c, {52'd0, c_a_mtvec}, 64'h8000_0100, t);
        f0 = o_flush_cnt;
        do_exec(c_sysop_ecall, 64'h8000_0040, 64'd0, 64'd0, t);
        chk("ecall_redir_lat", 64'(o_redir_cyc - t), 64'd2);
        chk("ecall_done_lat", 64'(o_done_cyc - t), 64'd2);
        chk("ecall_rpc", o_rpc, 64'h8000_0100);
        chk("ecall_rdata", o_rdata, 64'd0);
        chk("ecall_noflush", 64'(o_flush_cnt - f0), 64'd0);

        // satp write with delayed ack
        force_d = 5;
        f0 = o_flush_cnt;
        do_exec(c_sysop_csr_w, 64'h8000_0200, {52'd0, c_a_satp}, 64'h8000_0000_0001_2345, t);
        force_d = 0;
        chk("satp_flush_cycles", 64'(o_flush_cnt - f0), 64'd5);
        chk("satp_rpc", o_rpc, 64'h8000_0204);
        chk("satp_redir_lat", 64'(o_redir_cyc - t), 64'd7);
        chk("satp_done_lat", 64'(o_done_cyc - t), 64'd7);

        // Fault beats same-cycle exec
        r0 = o_redir_cnt;
        p_cause = c_sysop_csr_s; p_pc = 64'h8000_0300; p_addr = {52'd0, c_a_mtval};
        p_wdata = 64'd0; p_valid = 1;
        f_cause = c_mc_inst_pf; f_pc = 64'h8000_0300; f_va = 64'hDEAD_0000; f_pend = 1;
        step();
        chk("prio_ready", 64'(o_ready), 64'd0);
        wait_accept();
        wait_idle();
        chk("prio_redirs", 64'(o_redir_cnt - r0), 64'd1);
        chk("prio_rpc", o_rpc, 64'h8000_0100);
        chk("prio_mtval", o_rdata, 64'hDEAD_0000);

        // Fault buffer overflow during a flush
        force_d = 8;
        r0 = o_redir_cnt;
        p_cause = c_sysop_csr_w; p_pc = 64'h8000_0400; p_addr = {52'd0, c_a_satp};
        p_wdata = 64'h55; p_valid = 1;
        wait_accept();
        step(); step(); step();
        d0 = o_drop_cnt;
        f_cause = c_mc_load_pf; f_pc = 64'h8000_0500; f_va = 64'hBEEF_1000; f_pend = 1;
        step(); step();
        f_cause = c_mc_load_pf; f_pc = 64'h8000_0600; f_va = 64'hBEEF_2000; f_pend = 1;
        step();
        chk("ovf_drops", 64'(o_drop_cnt - d0), 64'd1);
        wait_idle();
        force_d = 0;
        chk("ovf_redirs", 64'(o_redir_cnt - r0), 64'd2);
        do_exec(c_sysop_csr_s, 64'h8000_0700, {52'd0, c_a_mtval}, 64'd0, t);
        chk("ovf_mtval", o_rdata, 64'hBEEF_1000);

        // Reset during flush
        force_d = 20;
        p_cause = c_sysop_csr_w; p_pc = 64'h8000_0800; p_addr = {52'd0, c_a_satp};
        p_wdata = 64'h77; p_valid = 1;
        wait_accept();
        step(); step(); step(); step();
        chk("pre_rst_flush", 64'(tlb_flush_req), 64'd1);
        r0 = o_redir_cnt;
        rst_next = 1;
        step();
        chk("rst_flush_req", 64'(tlb_flush_req), 64'd0);
        chk("rst_mid_cause", 64'(csr_cause), 64'(c_idle_cause));
        step();
        rst_next = 0;
        force_d = 0;
        step();
        chk("post_rst_ready", 64'(exec_ready), 64'd1);
        step(); step(); step(); step(); step();
        chk("rst_no_redirect", 64'(o_redir_cnt - r0), 64'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (!p_valid && $urandom_range(0, 2) == 0) begin
                sel = int'($urandom_range(0, 9));
                case (sel)
                    3, 4:    p_cause = c_sysop_csr_s;
                    5:       p_cause = c_sysop_csr_c;
                    6:       p_cause = c_sysop_ecall;
                    7:       p_cause = c_sysop_ret;
                    default: p_cause = c_sysop_csr_w;
                endcase
                p_addr  = {$urandom, 20'd0, addrs[$urandom_range(0, 6)]};
                p_pc    = {32'd0, $urandom & 32'hFFFF_FFFC};
                p_wdata = {$urandom, $urandom};
                p_valid = 1;
            end
            if ($urandom_range(0, 9) == 0) begin
                f_cause = ($urandom_range(0, 1) == 0) ? c_mc_inst_pf : c_mc_load_pf;
                f_pc = {32'd0, $urandom};
                f_va = {$urandom, $urandom};
                f_pend = 1;
            end
            step();
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csr_sched.md
# csr_sched

Sequencer and arbiter in front of the single-ported `csr` unit. It accepts system-op requests from the execute stage and page-fault reports from the MMU, and issues exactly one operation per sequence onto the `csr` cause/tval/wdata interface. It then resolves the result as one of three outcomes: a write-back response, a pipeline redirect, or a TLB-flush-then-redirect after a `satp` write. It sits between the pipeline/MMU and `csr`, and owns the global redirect.

## Interface
- `IDLE_CAUSE`, 5'd0: cause value driven to `csr` whenever no operation is issued.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `exec_valid`  in  1  execute-stage system-op request; held until accepted.
- `exec_ready`  out  1  request accepted on the edge where valid&ready.
- `exec_cause`  in  5  one of `SYSOP_CSR_W`, `SYSOP_CSR_S`, `SYSOP_CSR_C`, `SYSOP_ECALL`, `SYSOP_RET`.
- `exec_pc`  in  64  pc of the instruction.
- `exec_addr`  in  64  CSR index (bits 11:0 significant); don't-care for ECALL/RET.
- `exec_wdata`  in  64  CSR write operand.
- `exec_done`  out  1  one-cycle completion pulse for an exec-sourced sequence.
- `exec_rdata`  out  64  old CSR value; valid with `exec_done`; 0 for non-CSR ops.
- `fault_valid`  in  1  single-cycle page-fault pulse.
- `fault_cause`  in  5  `MCAUSE_LOAD_PAGE_FAULT` or `MCAUSE_INST_PAGE_FAULT`.
- `fault_pc`  in  64  faulting pc.
- `fault_va`  in  64  faulting virtual address.
- `fault_drop`  out  1  pulse: a fault arrived while the fault buffer was full and was discarded.
- `csr_cause`, `csr_pc`, `csr_tval`, `csr_wdata`  out  5/64/64/64  drive the `csr` unit.
- `csr_rdata`, `csr_r_valid`, `csr_trap_en`, `csr_trap_pc`, `csr_invalid`  in  64/1/1/64/1  combinational results from `csr`.
- `tlb_flush_req`  out  1  level request to flush the TLB.
- `tlb_flush_ack`  in  1  flush complete (single-cycle or level).
- `redirect_valid`  out  1  one-cycle pipeline flush and redirect.
- `redirect_pc`  out  64  target pc; valid with `redirect_valid`.
- `busy`  out  1  state ≠ IDLE or fault buffer full.

## Operation
- **Fault buffer:** one entry holding {cause, pc, va}.
  - `fault_valid` loads it on any cycle when it is empty.
  - It empties when its sequence is launched.
  - A `fault_valid` while the buffer is full, and not simultaneously being launched, asserts `fault_drop` for 1 cycle. The buffer contents are kept.
- **Accept:** `exec_ready = (state==IDLE) & buffer empty & ~fault_valid`. A fault therefore always beats a same-cycle exec request.
- **Launch (IDLE):**
  - A full fault buffer launches with src=FAULT, latching tval=va and wdata=0.
  - Otherwise an accepted exec request launches with src=EXEC, latching tval=addr.
- **ISSUE (exactly 1 cycle):**
  - `csr_cause`/`csr_pc`/`csr_tval`/`csr_wdata` carry the latched operation.
  - The block registers `csr_rdata` (0 if `~csr_r_valid`), `csr_trap_en`, `csr_trap_pc` and `csr_invalid`.
  - Next state: invalid → FLUSH; else trap_en → REDIRECT; else → RESP.
- **FLUSH:** `tlb_flush_req`=1 until the cycle `tlb_flush_ack`=1, then REDIRECT. No timeout.
- **REDIRECT (1 cycle):**
  - `redirect_valid`=1 with `redirect_pc` = latched trap_pc.
  - If src=EXEC, `exec_done`=1 with `exec_rdata` in the same cycle.
  - Next state: IDLE.
- **RESP (1 cycle):** `exec_done`=1 with `exec_rdata`. Next state: IDLE.
- **Outside ISSUE:** `csr_cause` = `IDLE_CAUSE`. `csr_pc`/`csr_tval`/`csr_wdata` hold their last latched values, so `csr` never sees a spurious op.
- **Reset:**
  - State goes to IDLE and the buffer empties.
  - All outputs go to 0, except `csr_cause` = `IDLE_CAUSE`.
  - Reset mid-sequence aborts it: no redirect, no `exec_done`, and `tlb_flush_req` drops immediately.

## Timing
- Exec accepted in cycle T:
  - ISSUE at T+1.
  - RESP or REDIRECT at T+2 (no flush).
  - IDLE at T+3, so the next accept is at T+3 at the earliest.
- `satp` write accepted at T: ISSUE T+1, FLUSH from T+2, REDIRECT the cycle after ack is seen.
- `fault_valid` at T, block idle:
  - Buffer full at T+1.
  - Launch at T+1, ISSUE at T+2, REDIRECT at T+3 with pc = `MTVEC` value.
  - `exec_ready`=0 during T and T+1.
- `fault_valid` while busy: held in the buffer, launched on the first IDLE cycle, ahead of any exec request.
- `exec_done` and `redirect_valid` are never high for more than 1 cycle per sequence.

## Test plan
- CSR write: exec `SYSOP_CSR_W`, addr=`MSCRATCH`, wdata=0x1234, previous value 0 → `exec_done` at T+2 with rdata=0; then `SYSOP_CSR_S`, wdata=0xF0 → rdata=0x1234, register reads 0x12F4.
- ECALL: `MTVEC`=0x8000_0100, exec ECALL pc=0x8000_0040 → `redirect_valid` and `exec_done` at T+2, `redirect_pc`=0x8000_0100, no `tlb_flush_req`.
- `satp` write: CSR_W to `SATP`, pc=0x8000_0200, ack held off 5 cycles → `tlb_flush_req` high 5 cycles, then `redirect_pc`=0x8000_0204, `exec_done` in the same cycle.
- Fault priority: `fault_valid` (INST_PAGE_FAULT, va=0xDEAD_0000) and `exec_valid` in the same cycle → `exec_ready`=0; redirect to `MTVEC`; `MTVAL` reads 0xDEAD_0000; the exec request is accepted afterward only if still held.
- Overflow: two faults during a pending FLUSH → first buffered, second asserts `fault_drop` for 1 cycle; exactly one fault redirect follows.
- Reset during FLUSH: assert `rst` with `tlb_flush_req`=1 → all outputs 0, `csr_cause`=`IDLE_CAUSE`, no redirect; after release, `exec_ready`=1.
